// File: rtl/tstate_pkg.sv
// Shared definitions for the 2-bit T-flip-flop state encoder and its decoder:
// state type and constants, decoder FSM states, and the encoder transition function.
package tstate_pkg;

    typedef logic [1:0] tstate_t;

    localparam tstate_t S00 = 2'b00;
    localparam tstate_t S01 = 2'b01;
    localparam tstate_t S10 = 2'b10;
    localparam tstate_t S11 = 2'b11;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        HALT = 1'b1
    } fsm_t;

    // Encoder next state for a given previous state and input bit.
    function automatic tstate_t next_state(input tstate_t prev, input logic x);
        tstate_t nxt;
        case (prev)
            S00:     nxt = x ? S00 : S01;
            S01:     nxt = x ? S10 : S11;
            S10:     nxt = x ? S10 : S11;
            S11:     nxt = x ? S11 : S00;
            default: nxt = S00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tstate_packer.sv
// Packs recovered bits into WORD_W-bit words, first bit in the LSB.
// clear_i drops the partial word and returns the bit index to 0.
module tstate_packer
    import tstate_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_i,
    input  logic              bit_i,
    input  logic              clear_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int                IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_valid_q, word_valid_d;

    // Next-state: right shift so that after WORD_W bits the first one sits in the LSB.
    always_comb begin
        idx_d        = idx_q;
        shreg_d      = shreg_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            idx_d   = '0;
            shreg_d = '0;
        end else if (shift_i) begin
            shreg_d = {bit_i, shreg_q[WORD_W-1:1]};
            if (idx_q == LAST_IDX) begin
                idx_d        = '0;
                word_d       = shreg_d;
                word_valid_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Packer state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            shreg_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shreg_q      <= shreg_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/tstate_decoder.sv
// Recovers encoder input bits from the observed {A,B} state stream and flags illegal transitions.
// Optional TSTATE_DEC_RESYNC_EN: resynchronise on an illegal sample instead of halting.
module tstate_decoder
    import tstate_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [1:0]        in_state,
    output logic              bit_valid,
    output logic              bit_x,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              sync
);

    fsm_t       state_q, state_d;
    tstate_t    prev_q, prev_d;
    logic       bit_valid_q, bit_valid_d;
    logic       bit_x_q, bit_x_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       sync_q, sync_d;

    logic       legal_s;
    logic       x_s;
    logic       accept_s;
    logic       good_s;
    logic       bad_s;

    // Invert the encoder: find the x that maps prev to the observed state, if any.
    always_comb begin
        legal_s = 1'b0;
        x_s     = 1'b0;
        if (next_state(prev_q, 1'b0) == tstate_t'(in_state)) begin
            legal_s = 1'b1;
            x_s     = 1'b0;
        end else if (next_state(prev_q, 1'b1) == tstate_t'(in_state)) begin
            legal_s = 1'b1;
            x_s     = 1'b1;
        end else begin
            legal_s = 1'b0;
            x_s     = 1'b0;
        end
    end

    assign accept_s = in_valid && (state_q == SYNC);
    assign good_s   = accept_s && legal_s;
    assign bad_s    = accept_s && !legal_s;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only an illegal sample without resync leaves SYNC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC: begin
`ifdef TSTATE_DEC_RESYNC_EN
                state_d = SYNC;
`else
                if (bad_s) begin
                    state_d = HALT;
                end else begin
                    state_d = SYNC;
                end
`endif
            end
            HALT:    state_d = HALT;
            default: state_d = SYNC;
        endcase
    end

    // Output and tracking next values; bit_x holds between pulses.
    always_comb begin
        bit_valid_d = good_s;
        err_d       = bad_s;
        bit_x_d     = bit_x_q;
        prev_d      = prev_q;
        err_cnt_d   = err_cnt_q;
        sync_d      = (state_d == SYNC);
        if (good_s) begin
            bit_x_d = x_s;
            prev_d  = tstate_t'(in_state);
        end else if (bad_s) begin
`ifdef TSTATE_DEC_RESYNC_EN
            prev_d = tstate_t'(in_state);
`else
            prev_d = prev_q;
`endif
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            bit_x_d = bit_x_q;
        end
    end

    // Tracking state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q      <= S00;
            bit_valid_q <= 1'b0;
            bit_x_q     <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
            sync_q      <= 1'b1;
        end else begin
            prev_q      <= prev_d;
            bit_valid_q <= bit_valid_d;
            bit_x_q     <= bit_x_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            sync_q      <= sync_d;
        end
    end

    tstate_packer #(
        .WORD_W(WORD_W)
    ) u_packer (
        .clk         (clk),
        .reset       (reset),
        .shift_i     (good_s),
        .bit_i       (x_s),
        .clear_i     (bad_s),
        .word_valid_o(word_valid),
        .word_o      (word)
    );

    assign bit_valid = bit_valid_q;
    assign bit_x     = bit_x_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign sync      = sync_q;

endmodule

// File: tb/tb_tstate_decoder.sv
// Self-checking bench for tstate_decoder: directed scenarios plus random legal/illegal
// streams compared against a table-driven reference model.
module tb_tstate_decoder;

    localparam int W = 8;

`ifdef TSTATE_DEC_RESYNC_EN
    localparam bit RESYNC = 1'b1;
`else
    localparam bit RESYNC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   in_state;
    logic         bit_valid;
    logic         bit_x;
    logic         word_valid;
    logic [W-1:0] word;
    logic         err;
    logic [7:0]   err_cnt;
    logic         sync;

    tstate_decoder #(.WORD_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_state  (in_state),
        .bit_valid (bit_valid),
        .bit_x     (bit_x),
        .word_valid(word_valid),
        .word      (word),
        .err       (err),
        .err_cnt   (err_cnt),
        .sync      (sync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [1:0]   nxt [4][2];
    logic [1:0]   m_prev;
    bit           m_halted;
    logic [7:0]   m_cnt;
    logic         m_bv, m_bx, m_wv, m_err;
    logic [W-1:0] m_word;
    bit           q_bits[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev   = 2'b00;
        m_halted = 1'b0;
        m_cnt    = 8'd0;
        m_bv     = 1'b0;
        m_bx     = 1'b0;
        m_wv     = 1'b0;
        m_err    = 1'b0;
        m_word   = '0;
        q_bits.delete();
    endtask

    task automatic model_step(input logic v, input logic [1:0] s);
        bit found = 1'b0;
        bit xx    = 1'b0;
        m_bv  = 1'b0;
        m_wv  = 1'b0;
        m_err = 1'b0;
        if (v && !m_halted) begin
            for (int x = 0; x < 2; x++) begin
                if (!found && nxt[m_prev][x] == s) begin
                    found = 1'b1;
                    xx    = x[0];
                end
            end
            if (found) begin
                m_bv   = 1'b1;
                m_bx   = xx;
                m_prev = s;
                q_bits.push_back(xx);
                if (q_bits.size() == W) begin
                    for (int i = 0; i < W; i++) m_word[i] = q_bits[i];
                    m_wv = 1'b1;
                    q_bits.delete();
                end
            end else begin
                m_err = 1'b1;
                if (m_cnt < 8'd255) m_cnt = m_cnt + 8'd1;
                q_bits.delete();
                if (RESYNC) m_prev = s;
                else m_halted = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".bit_valid"}, 32'(bit_valid), 32'(m_bv));
        chk({where, ".bit_x"}, 32'(bit_x), 32'(m_bx));
        chk({where, ".word_valid"}, 32'(word_valid), 32'(m_wv));
        chk({where, ".word"}, 32'(word), 32'(m_word));
        chk({where, ".err"}, 32'(err), 32'(m_err));
        chk({where, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        chk({where, ".sync"}, 32'(sync), 32'(!m_halted));
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        in_valid = v;
        in_state = s;
        @(posedge clk);
        model_step(v, s);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [1:0] pick_legal();
        return nxt[m_prev][$urandom_range(0, 1)];
    endfunction

    function automatic logic [1:0] pick_illegal();
        logic [1:0] s;
        do begin
            s = 2'($urandom_range(0, 3));
        end while (s == nxt[m_prev][0] || s == nxt[m_prev][1]);
        return s;
    endfunction

    logic [1:0] seq1 [8];

    initial begin
        nxt[0][0] = 2'b01; nxt[0][1] = 2'b00;
        nxt[1][0] = 2'b11; nxt[1][1] = 2'b10;
        nxt[2][0] = 2'b11; nxt[2][1] = 2'b10;
        nxt[3][0] = 2'b00; nxt[3][1] = 2'b11;
        seq1 = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11};
        reset    = 1'b1;
        in_valid = 1'b0;
        in_state = 2'b00;
        model_reset();
        #12;
        check_all("por");
        reset = 1'b0;

        // Reference sequence producing word 0x26
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, seq1[i]);
        chk("word_0x26", 32'(word), 32'h26);
        chk("word_valid_last", 32'(word_valid), 32'd1);

        // First sample illegal
        do_reset();
        step(1'b1, 2'b10);
        chk("first_err_cnt", 32'(err_cnt), 32'd1);
        step(1'b1, 2'b10);
        chk("after_err_bv", 32'(bit_valid), 32'(RESYNC));

        // Error in the middle of a word discards the partial word
        do_reset();
        step(1'b1, 2'b01);
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        step(1'b1, 2'b10);
        for (int i = 0; i < 8; i++) step(1'b1, pick_legal());

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2 == 0) ? 2'b10 : 2'b00);
        chk("err_cnt_sat", 32'(err_cnt), RESYNC ? 32'd255 : 32'd1);

        // in_valid gaps with toggling state
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, pick_legal());
        for (int i = 0; i < 5; i++) step(1'b0, 2'(i));
        for (int i = 0; i < 6; i++) step(1'b1, pick_legal());

        // Reset in the middle of a word
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, pick_legal());
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, pick_legal());
        chk("post_reset_word_valid", 32'(word_valid), 32'd1);
        chk("post_reset_err_cnt", 32'(err_cnt), 32'd0);

        // Random streams with gaps and occasional illegal samples
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 5) == 0) step(1'b0, 2'($urandom_range(0, 3)));
                else if ($urandom_range(0, 19) == 0) step(1'b1, pick_illegal());
                else step(1'b1, pick_legal());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tstate_decoder.md
# tstate_decoder

Receive-side decoder for the 2-bit T-flip-flop state encoder. It observes the encoder's {A,B} state stream, one sample per accepted encoder clock, and recovers the input bit x that caused each transition. It flags transitions the encoder cannot produce and packs recovered bits into words. It sits at the far end of the link carrying encoder state, between the state sampler and the word consumer.

## Interface
- WORD_W, 8: recovered bits per output word (2..16)
- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- in_valid  input  1  in_state holds a new encoder state sample this cycle
- in_state  input  2  observed encoder state {A,B}
- bit_valid  output  1  one-cycle pulse: bit_x valid
- bit_x  output  1  recovered encoder input x
- word_valid  output  1  one-cycle pulse: word valid
- word  output  WORD_W  packed recovered bits, first bit in LSB
- err  output  1  one-cycle pulse: illegal transition detected
- err_cnt  output  8  illegal-transition count, saturating at 255
- sync  output  1  decoder tracking encoder state

## Operation
- Transition table, prev -> (x=0, x=1): 00 -> (01, 00); 01 -> (11, 10); 10 -> (11, 10); 11 -> (00, 11).
- Any other prev -> in_state pair is illegal: 00->10, 00->11, 01->00, 01->01, 10->00, 10->01, 11->01, 11->10.
- prev register resets to 00, matching the encoder reset state.
- Legal sample: emit x on bit_x with a bit_valid pulse, prev <= in_state, and shift x into the packer.
- Illegal sample: no bit emitted; err pulses; err_cnt increments, saturating at 255; the partial word is discarded and the bit index returns to 0.
- FSM states: SYNC (tracking) and HALT (entered only when resync is compiled out).
- Packer: bit index 0..WORD_W-1. When the bit at index WORD_W-1 is accepted, word is updated, word_valid pulses, and the index returns to 0.
- in_valid low: no state change and no output pulses.

## Timing
- All outputs are registered; reset values: bit_valid=0, bit_x=0, word_valid=0, word=0, err=0, err_cnt=0, sync=1.
- Latency: bit_valid/bit_x and err appear 1 cycle after the accepting in_valid edge. word_valid coincides with the bit_valid of the last bit.
- word holds its value until the next word completes.
- Back-to-back in_valid every cycle is supported at full rate; no backpressure.
- Reset mid-word: partial word is lost, prev=00, and the index returns to 0 immediately (asynchronous).
- Saturated err_cnt holds at 255 on further errors while err still pulses.

## Configuration
- TSTATE_DEC_RESYNC_EN defined: on an illegal sample, prev <= in_state, the FSM stays in SYNC, and decoding resumes with the next sample. sync stays 1.
- TSTATE_DEC_RESYNC_EN undefined: an illegal sample moves the FSM to HALT and sync goes to 0 in the same cycle as err. In HALT all samples are ignored: no bit_valid, no err, and err_cnt frozen. Only reset leaves HALT.

## Structure
- Shared package tstate_pkg holds:
  - the 2-bit state type and the constants S00, S01, S10, S11
  - the FSM enum {SYNC, HALT}
  - a function returning next state for (prev, x), shared with the encoder bench model
- Sub-module tstate_packer contains the WORD_W shift register, bit index, word and word_valid generation, and a clear input driven on error.

## Test plan
- Reset, then in_state 01,10,10,11,00,00,01,11 with in_valid every cycle -> bit_x 0,1,1,0,0,1,0,0, then word=0x26 with one word_valid pulse, err never high.
- After reset, in_state 10 -> err pulse, err_cnt=1, no bit_valid. With the macro, a following 10 decodes x=1; without it, sync=0 and the following 10 is ignored.
- Three legal bits, then illegal 11->10, then 8 legal bits -> one word containing only the post-error 8 bits (macro defined).
- 300 illegal samples with the macro defined -> err_cnt stops at 255 and err still pulses on each sample.
- in_valid low for 5 cycles mid-stream with in_state toggling -> no outputs change and decoding continues correctly afterwards.
- Reset asserted after 4 bits, released, then 8 legal bits from 00 -> word_valid after exactly 8 bits, err_cnt=0.
